challenge_sched: RTL
====================

CHALLENGE_SCHED -- requirements
Module: challenge_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of challenge requesters.
REQ-002 Parameter WORDS, default 2: 16-bit LFSR words concatenated per challenge.
REQ-003 Parameter STEPS_PER_WORD, default 4: LFSR advances between captured words.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester level request for a fresh challenge.
REQ-007 ack  input  NUM_REQ  per-requester consume strobe; only the granted bit is honoured.
REQ-008 lfsr_random  input  16  current state of the external 16-bit LFSR.
REQ-009 lfsr_enable  output  1  advance strobe to the external LFSR.
REQ-010 gnt  output  NUM_REQ  one-hot grant, zero when idle.
REQ-011 challenge  output  16*WORDS  assembled challenge, oldest word in the MSBs.
REQ-012 valid  output  1  challenge stable and owned by the gnt requester.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, STEP, CAPTURE, PRESENT.
REQ-015 IDLE: any req high at an edge -> grant the round-robin winner, clear step/word counters, go STEP.
REQ-016 Round-robin: search starts at last_grant+1 modulo NUM_REQ; last_grant updates when the grant is issued.
REQ-017 STEP: lfsr_enable=1 for exactly STEPS_PER_WORD consecutive cycles, then go CAPTURE.
REQ-018 CAPTURE: lfsr_enable=0; challenge <= {challenge[16*WORDS-17:0], lfsr_random}; after the WORDS-th capture go PRESENT, else STEP.
REQ-019 lfsr_enable SHALL never be high outside STEP.
REQ-020 Latency: valid rises WORDS*(STEPS_PER_WORD+1) edges after the IDLE edge that sampled req; default 10.
REQ-021 PRESENT: valid=1 and challenge and gnt held constant until exit.
REQ-022 PRESENT: ack bit matching gnt high -> next edge valid=0, gnt=0, go IDLE; ack on non-granted bits is ignored.
REQ-023 Withdrawal: granted req low in STEP, CAPTURE or PRESENT, without a matching ack, aborts to IDLE; valid never asserts for that grant; LFSR advances already made are not undone.
REQ-024 A granted requester's ack and req-drop in the same cycle SHALL be treated as ack.
REQ-025 Requests arriving while busy SHALL wait, unlatched, until the next IDLE evaluation.
REQ-026 challenge SHALL retain its last value after exit; only valid qualifies it.

Reset
REQ-027 rst high SHALL immediately force IDLE, gnt=0, valid=0, busy=0, lfsr_enable=0, challenge=0, counters=0, last_grant=NUM_REQ-1, so requester 0 wins first.
REQ-028 Reset mid-STEP SHALL drop lfsr_enable asynchronously; the external LFSR is reseeded by its own rst.

Structure
REQ-029 State encoding and the 16-bit word width SHALL live in the shared package challenge_pkg.
REQ-030 Round-robin selection SHALL be the sub-module rr_arbiter (req, last_grant -> one-hot winner, combinational).
REQ-031 The LFSR SHALL stay external; this block only drives its enable.

Verification
REQ-032 Defaults, LFSR seeded 16'hACE1, req[0] pulsed until ack -> valid after 10 cycles, gnt=4'b0001, challenge=32'hCE1EE1E4, lfsr_enable high for exactly 8 cycles.
REQ-033 req=4'b1111 held, each ack issued on its valid -> grants in order 0,1,2,3,0, with no two grants in one cycle.
REQ-034 req[2] only, dropped two cycles into STEP -> return to IDLE, valid never high, gnt=0 on the next edge.
REQ-035 In PRESENT, ack[1] high while gnt=4'b0001 -> no change; then ack[0] high -> valid=0 and IDLE on the next edge.
REQ-036 rst asserted mid-STEP -> all outputs 0 before the next clock edge; after release, req[3] alone is granted gnt=4'b1000.
REQ-037 ack[0] and req[0] fall together in PRESENT -> treated as ack, and last_grant=0 (next winner requester 1 if req=4'b0011).

Source files
------------

// File: rtl/challenge_pkg.sv
// ============================================================================
//  Module      : challenge_pkg
//  Description : Shared FSM encoding, word width and width helper for the
//                challenge scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package challenge_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick; search starts one past the
//                previous winner and wraps modulo NUM_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import challenge_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = cnt_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] gnt
);

  localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

  logic [IW:0] w_idx;
  logic        w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = {1'b0, last_grant} + (IW+1)'(i);
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req[w_idx[IW-1:0]]) begin
        gnt[w_idx[IW-1:0]] = 1'b1;
        w_found            = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/challenge_sched.sv
// ============================================================================
//  Module      : challenge_sched
//  Description : Grants one requester at a time, steps an external LFSR and
//                assembles WORDS captured words into a challenge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module challenge_sched
  import challenge_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WORDS          = 2,
  parameter int STEPS_PER_WORD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      ack,
  input  logic [WORD_W-1:0]       lfsr_random,
  output logic                    lfsr_enable,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [WORD_W*WORDS-1:0] challenge,
  output logic                    valid,
  output logic                    busy
);

  localparam int CW = WORD_W * WORDS;
  localparam int IW = cnt_w(NUM_REQ);
  localparam int SW = cnt_w(STEPS_PER_WORD);
  localparam int WW = cnt_w(WORDS);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_WORD - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IW-1:0]      r_last;
  logic [SW-1:0]      r_step;
  logic [WW-1:0]      r_word;
  logic [CW-1:0]      r_challenge;
  logic               r_enable;
  logic               r_valid;

  logic [NUM_REQ-1:0] w_win;
  logic [IW-1:0]      w_win_idx;
  logic [CW-1:0]      w_shifted;
  logic               w_held;
  logic               w_acked;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req        (req),
    .last_grant (r_last),
    .gnt        (w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) w_win_idx = IW'(i);
    end
  end

  generate
    if (WORDS > 1) begin : g_shift_multi
      assign w_shifted = {r_challenge[CW-WORD_W-1:0], lfsr_random};
    end else begin : g_shift_single
      assign w_shifted = lfsr_random;
    end
  endgenerate

  assign w_held  = |(req & r_gnt);
  assign w_acked = |(ack & r_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_last      <= LAST_INIT;
      r_step      <= '0;
      r_word      <= '0;
      r_challenge <= '0;
      r_enable    <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt    <= w_win;
            r_last   <= w_win_idx;
            r_step   <= '0;
            r_word   <= '0;
            r_enable <= 1'b1;
            r_state  <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (!w_held) begin
            r_gnt    <= '0;
            r_enable <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (r_step == STEP_LAST) begin
            r_step   <= '0;
            r_enable <= 1'b0;
            r_state  <= ST_CAPTURE;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (!w_held) begin
            r_gnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_challenge <= w_shifted;
            if (r_word == WORD_LAST) begin
              r_valid <= 1'b1;
              r_state <= ST_PRESENT;
            end else begin
              r_word   <= r_word + 1'b1;
              r_enable <= 1'b1;
              r_state  <= ST_STEP;
            end
          end
        end
        ST_PRESENT: begin
          // Ack and withdrawal both leave; last_grant was fixed at grant time.
          if (w_acked || !w_held) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_gnt    <= '0;
          r_enable <= 1'b0;
          r_valid  <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign lfsr_enable = r_enable;
  assign gnt         = r_gnt;
  assign challenge   = r_challenge;
  assign valid       = r_valid;
  assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire
